// File: rtl/wasca_hex_ctrl_pkg.sv
// Shared definitions for the 7-segment controller: register map, CTRL bits,
// scan FSM states and the active-low segment table.
package wasca_hex_ctrl_pkg;

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_BLANK = 2'd1;
  localparam logic [1:0] ADDR_BLINK = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RESTART = 1;
  localparam int CTRL_PHASE   = 2;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Segment codes for hex digits; entry 0 is the rightmost element.
  // Bit 0 is segment a, bit 6 is segment g. A 0 bit lights the segment.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } scan_state_t;

endpackage

// File: rtl/wasca_hex_ctrl_seg_decode.sv
// Nibble to active-low 7-segment pattern. Pure combinational logic.
module wasca_hex_ctrl_seg_decode
  import wasca_hex_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Look up the segment pattern for this nibble.
  always_comb begin
    seg = SEG_TAB[nibble];
  end

endmodule

// File: rtl/wasca_hex_ctrl.sv
// Avalon-MM 7-segment controller. Software-visible registers feed a scan FSM.
// The FSM decodes one digit per cycle into a shadow buffer, then commits every
// digit to hex_out in a single cycle so the display never shows a torn update.
module wasca_hex_ctrl
  import wasca_hex_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int VW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [VW-1:0]                 value_r;
  logic [NUM_DIGITS-1:0][3:0]    value_v;
  logic [NUM_DIGITS-1:0]         blank_r, blink_r;
  logic                          en_r, phase_r, phase_nxt, phase_chg;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic                          dirty, dirty_clr;
  logic                          wr, restart;
  scan_state_t                   state, state_nxt;
  logic                          scan_en, commit;
  logic [IDX_W-1:0]              idx;
  logic [3:0]                    nib;
  logic [6:0]                    seg, digit;
  logic                          digit_off;
  logic [NUM_DIGITS-1:0][6:0]    shadow, hex_r;
  logic                          unused_wd;

  assign wr        = chipselect & ~write_n;
  assign restart   = wr && (address == ADDR_CTRL) && writedata[CTRL_RESTART];
  assign unused_wd = &{1'b0, writedata};
  assign value_v   = value_r;
  assign hex_out   = hex_r;

  // Software registers; bits beyond the digit count are simply not stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_r <= '0;
      blank_r <= '0;
      blink_r <= '0;
      en_r    <= 1'b0;
    end else if (wr) begin
      case (address)
        ADDR_VALUE: value_r <= writedata[VW-1:0];
        ADDR_BLANK: blank_r <= writedata[NUM_DIGITS-1:0];
        ADDR_BLINK: blink_r <= writedata[NUM_DIGITS-1:0];
        ADDR_CTRL:  en_r    <= writedata[CTRL_EN];
        default: ;
      endcase
    end
  end

  // Combinational read mux, zero-extended.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_VALUE: readdata = 32'(value_r);
      ADDR_BLANK: readdata = 32'(blank_r);
      ADDR_BLINK: readdata = 32'(blink_r);
      ADDR_CTRL: begin
        readdata[CTRL_EN]    = en_r;
        readdata[CTRL_PHASE] = phase_r;
      end
      default: ;
    endcase
  end

  // Prescaler next state; RESTART wins over the natural wrap.
  always_comb begin
    cnt_nxt   = cnt + 1'b1;
    phase_nxt = phase_r;
    if (restart) begin
      cnt_nxt   = '0;
      phase_nxt = 1'b1;
    end else if (cnt == CNT_MAX) begin
      cnt_nxt   = '0;
      phase_nxt = ~phase_r;
    end
  end

  assign phase_chg = phase_nxt ^ phase_r;

  // Prescaler and blink phase registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      phase_r <= 1'b1;
    end else begin
      cnt     <= cnt_nxt;
      phase_r <= phase_nxt;
    end
  end

  // Dirty flag: a new event in the same cycle as the FSM taking it keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              dirty <= 1'b0;
    else if (wr || phase_chg)  dirty <= 1'b1;
    else if (dirty_clr)        dirty <= 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (dirty) state_nxt = ST_SCAN;
      ST_SCAN:   if (idx == IDX_LAST) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    dirty_clr = (state == ST_IDLE) && dirty;
    scan_en   = (state == ST_SCAN);
    commit    = (state == ST_COMMIT);
  end

  // Digit index: cleared when a scan starts, advances through the scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       idx <= '0;
    else if (dirty_clr)                 idx <= '0;
    else if (scan_en && idx != IDX_LAST) idx <= idx + 1'b1;
  end

  // One shared decoder on the nibble selected by idx.
  assign nib = value_v[idx];

  wasca_hex_ctrl_seg_decode u_dec (
    .nibble (nib),
    .seg    (seg)
  );

  // Blanking is evaluated from the live registers at the moment the digit is scanned.
  always_comb begin
    digit_off = ~en_r | blank_r[idx] | (blink_r[idx] & ~phase_r);
    digit     = digit_off ? SEG_OFF : seg;
  end

  // Shadow buffer filled one digit per scan cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     shadow      <= {NUM_DIGITS{SEG_OFF}};
    else if (scan_en) shadow[idx] <= digit;
  end

  // Visible outputs change only on commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    hex_r <= {NUM_DIGITS{SEG_OFF}};
    else if (commit) hex_r <= shadow;
  end

endmodule

// File: tb/tb_wasca_hex_ctrl.sv
// Directed bench for wasca_hex_ctrl (6 digits, blink divider 8).
// Writes are aligned to blink-phase toggles so display latency is deterministic;
// expected display/readback values are queued with a due cycle and checked then.
module tb_wasca_hex_ctrl;

  localparam int ND = 6;
  localparam logic [41:0] ALL_OFF = {ND{7'h7F}};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd3;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [41:0] hex_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int          due;
    bit          kind;   // 0: hex_out, 1: readdata at CTRL
    logic [41:0] exp;
    string       tag;
  } sb_t;
  sb_t sb[$];

  logic [23:0] m_value;
  logic [5:0]  m_blank, m_blink;
  logic        m_en;

  wasca_hex_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hex_out    (hex_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [41:0] model(logic ph);
    logic [41:0] r;
    logic [3:0]  n;
    r = '0;
    for (int d = 0; d < ND; d++) begin
      n = m_value[4*d +: 4];
      if (!m_en || m_blank[d] || (m_blink[d] && !ph)) r[7*d +: 7] = 7'h7F;
      else                                           r[7*d +: 7] = seg_ref[n];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int due, input bit kind, input logic [41:0] exp, input string tag);
    sb_t e;
    e.due = due; e.kind = kind; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  // Wait for each queued entry's due cycle and compare.
  task automatic drain();
    sb_t e;
    int  guard;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      guard = 0;
      while (cyc < e.due && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (e.kind) chk(e.tag, {10'b0, readdata}, e.exp);
      else        chk(e.tag, hex_out, e.exp);
    end
  endtask

  // Find a phase toggle edge k, then have a write accepted at edge k+off.
  // Returns the cycle count sampled just after the accepting edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input int off, output int w);
    logic prev;
    bit   found;
    address = 2'd3; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    prev  = readdata[2];
    found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (readdata[2] !== prev) found = 1;
    end
    chk("align_timeout", {41'b0, found}, 42'd1);
    repeat (off - 1) @(posedge clk);
    @(negedge clk);
    address = a; writedata = d; write_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    write_n = 1'b1; address = 2'd3;
    w = cyc;
  endtask

  task automatic model_reset();
    m_value = '0; m_blank = '0; m_blink = '0; m_en = 1'b0;
  endtask

  // Enable, then load 0x0012AF; both must show exactly 8 cycles after the write edge.
  task automatic bring_up(input string pfx);
    int w;
    logic [41:0] old;
    old = model(1'b1);
    bus_write(2'd3, 32'h1, 8, w);
    m_en = 1'b1;
    push(w + 7, 0, old, {pfx, "_en_c7"});
    push(w + 8, 0, model(1'b1), {pfx, "_en_c8"});
    drain();
    old = model(1'b1);
    bus_write(2'd0, 32'h0012AF, 8, w);
    m_value = 24'h0012AF;
    push(w + 7, 0, old, {pfx, "_val_c7"});
    push(w + 8, 0, {7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E}, {pfx, "_val_c8"});
    drain();
  endtask

  initial begin
    int w;
    model_reset();

    // 1: reset state and idle stability
    repeat (3) @(negedge clk);
    chk("rst_hex", hex_out, ALL_OFF);
    address = 2'd3;
    #1 chk("rst_ctrl", {10'b0, readdata}, 42'h4);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      chk("idle_hex", hex_out, ALL_OFF);
    end

    // 2: enable and value
    bring_up("t2");

    // 3: blank digit 5, upper write bits ignored
    bus_write(2'd1, 32'hFFFF_FFE0, 8, w);
    m_blank = 6'h20;
    push(w + 8, 0, model(1'b1), "t3_blank_hex");
    drain();
    address = 2'd1;
    #1 chk("t3_blank_rd", {10'b0, readdata}, 42'h20);
    address = 2'd3;

    // 4: blink digit 0 after RESTART
    bus_write(2'd2, 32'h1, 8, w);
    m_blink = 6'h01;
    bus_write(2'd3, 32'h3, 8, w);
    push(w + 1,  1, 42'h5, "t4_ctrl_ph1");
    push(w + 8,  0, model(1'b1), "t4_on0");
    push(w + 9,  1, 42'h1, "t4_ctrl_ph0");
    push(w + 16, 0, model(1'b0), "t4_off");
    push(w + 17, 1, 42'h5, "t4_ctrl_ph1b");
    push(w + 24, 0, model(1'b1), "t4_on1");
    drain();
    chk("t4_digit0_on_code", {35'b0, hex_out[6:0]}, 42'h0E);

    // 5: write during scan at idx=3
    bus_write(2'd2, 32'h0, 8, w);
    m_blink = '0;
    push(w + 8, 0, model(1'b1), "t5_noblink");
    drain();
    bus_write(2'd1, 32'h0, 8, w);
    m_blank = '0;
    push(w + 8, 0, model(1'b1), "t5_noblank");
    drain();
    bus_write(2'd0, 32'h111111, 5, w);
    push(w + 3, 0, {7'h79, 7'h79, 7'h79, 7'h24, 7'h08, 7'h0E}, "t5_mixed");
    push(w + 11, 0, {ND{7'h79}}, "t5_second");
    drain();
    m_value = 24'h111111;

    // 6: reset mid-scan
    bus_write(2'd0, 32'h00ABCD, 8, w);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1 chk("t6_hex", hex_out, ALL_OFF);
    address = 2'd0; #1 chk("t6_value", {10'b0, readdata}, 42'h0);
    address = 2'd1; #1 chk("t6_blank", {10'b0, readdata}, 42'h0);
    address = 2'd2; #1 chk("t6_blink", {10'b0, readdata}, 42'h0);
    address = 2'd3; #1 chk("t6_ctrl",  {10'b0, readdata}, 42'h4);
    repeat (3) @(negedge clk);
    chk("t6_hex_hold", hex_out, ALL_OFF);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_idle", hex_out, ALL_OFF);
    bring_up("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
